ipmaxi_wr: RTL and testbench
============================

# ipmaxi_wr

AXI4 write-master front end. Accepts single write beats (address, data, byte enables) on a simple valid/ready port and coalesces runs of address-contiguous beats into AXI4 INCR bursts on the AW/W channels. Sits between powlib internal write sources and an AXI4 slave or interconnect.

## Interface
- MAX_BURST, 128: max beats per burst (1..256); also the buffer depth
- ID, "TEST": instance name string, used only in debug messages
- EAR, 0: kept for port compatibility only; reset is always asynchronous
- EDBG, 0: runtime enable for debug messages when the monitor is compiled in
- B_BPD, 4: bytes per data word (power of two)
- B_AW, 8*B_BPD: address width
- B_DW, 8*B_BPD: data width
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-low
- wraddr  in  B_AW  beat byte address; low log2(B_BPD) bits ignored
- wrdata  in  B_DW  beat data
- wrbe  in  B_BPD  beat byte enables
- wrvld  in  1  beat valid
- wrrdy  out  1  beat accepted when wrvld&&wrrdy
- wrnf  out  1  nearly full: buffer holds >= MAX_BURST-1 beats, or a burst is being issued
- awaddr  out  B_AW; awlen  out  8; awsize  out  3; awburst  out  2; awvalid  out  1; awready  in  1
- wdata  out  B_DW; wstrb  out  B_BPD; wlast  out  1; wvalid  out  1; wready  in  1
- bvalid  in  1; bresp  in  2; bready  out  1, held at 1 out of reset

## Operation
- States: IDLE, COLLECT, ADDR, DATA.
- IDLE: wrrdy=1. An accepted beat is written to the buffer; base=aligned wraddr; count=1; go to COLLECT.
- COLLECT: a beat is accepted only if aligned wraddr == base+count*B_BPD and count<MAX_BURST; wrrdy is combinational on wraddr (ready depends on valid; permitted).
- Burst closes (go to ADDR) when any of: wrvld low; presented beat non-contiguous (stays pending, not accepted); count reaches MAX_BURST; next address is 4 KB aligned (addr[11:0]==0).
- ADDR: awvalid=1, awaddr=base, awlen=count-1, awsize=log2(B_BPD), awburst=2'b01; hold all stable until awready; then DATA.
- DATA: buffered beats issued in order, wvalid=1, wstrb=stored wrbe, wlast on last beat only; hold stable until wready; after last handshake go to IDLE.
- wrrdy=0 in ADDR and DATA.
- B channel: bready=1; responses are discarded except by the debug monitor.

## Timing
- Reset values: wrrdy=0 during reset, awvalid=0, wvalid=0, wlast=0, awaddr=0, awlen=0, wdata=0, wstrb=0, bready=0; count=0; state IDLE.
- First cycle after reset release: wrrdy=1, bready=1.
- Close-to-awvalid latency: 1 cycle; awvalid registered.
- First wvalid: the cycle after the AW handshake.
- Each W beat: 1 cycle when wready=1.
- Min burst turnaround: last W handshake -> wrrdy=1 next cycle.
- awvalid/wvalid never drop before their handshake.
- Reset mid-burst: buffer discarded; outputs return to reset values immediately.

## Configuration
- IPMAXI_WR_DEBUG_EN defined: monitor compiled in; when EDBG!=0, $display "ID: AW addr=.. len=.." per AW handshake and reports any bresp!=0.
- Undefined: no monitor logic; EDBG has no effect.

## Structure
- Shared package holds POWLIB_BW=8, AXI_LENW=8, AXI_SIZEW=3, AXI_BURSTW=2, AXI_BURST_INCR=2'b01, and a state enum.
- One sub-module, ipmaxi_wr_buf: synchronous FIFO, MAX_BURST deep, {wrdata,wrbe}, with count output.

## Test plan
- Reset asserted -> all outputs at reset values; release -> wrrdy=1, bready=1.
- 4 beats at 0x100,0x104,0x108,0x10C, then wrvld=0 -> one AW: addr 0x100, len 3, size 2, burst 1; 4 W beats, wlast on the 4th only.
- 130 contiguous beats from 0x0 -> AW len 127 at 0x0, then AW len 1 at 0x200.
- Beats at 0xFF8,0xFFC,0x1000 -> AW 0xFF8 len 1, then AW 0x1000 len 0.
- Beats at 0x0 then 0x40 back-to-back -> 0x40 held (wrrdy=0) until first burst completes; two len-0 bursts.
- wready toggling 0/1 during DATA -> wdata/wstrb stable while stalled; awvalid held until delayed awready.

Source files
------------

// File: rtl/ipmaxi_wr_pkg.sv
// Shared widths, AXI encodings and the front-end state enum for ipmaxi_wr.
package ipmaxi_wr_pkg;

    localparam int POWLIB_BW  = 8;
    localparam int AXI_LENW   = 8;
    localparam int AXI_SIZEW  = 3;
    localparam int AXI_BURSTW = 2;

    localparam logic [AXI_BURSTW-1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StAddr,
        StData
    } state_t;

endpackage

// File: rtl/ipmaxi_wr_buf.sv
// Beat buffer for ipmaxi_wr: synchronous first-word-fall-through FIFO with occupancy count.
module ipmaxi_wr_buf #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned W     = 36,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_rd,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Depth need not be a power of two, so pointers wrap explicitly.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_wr) begin
                r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
            end
            if (i_rd) begin
                r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
            end
            case ({i_wr, i_rd})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_cnt;

endmodule

// File: rtl/ipmaxi_wr.sv
// AXI4 write-master front end: coalesces address-contiguous beats into INCR bursts.
// Define IPMAXI_WR_DEBUG_EN to compile in the AW/B debug monitor (gated at runtime by EDBG).
module ipmaxi_wr
    import ipmaxi_wr_pkg::*;
#(
    parameter int unsigned MAX_BURST = 128,
    parameter              ID        = "TEST",
    parameter int          EAR       = 0,
    parameter int          EDBG      = 0,
    parameter int unsigned B_BPD     = 4,
    parameter int unsigned B_AW      = 8 * B_BPD,
    parameter int unsigned B_DW      = 8 * B_BPD
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [B_AW-1:0]       i_wraddr,
    input  logic [B_DW-1:0]       i_wrdata,
    input  logic [B_BPD-1:0]      i_wrbe,
    input  logic                  i_wrvld,
    output logic                  o_wrrdy,
    output logic                  o_wrnf,
    output logic [B_AW-1:0]       o_awaddr,
    output logic [AXI_LENW-1:0]   o_awlen,
    output logic [AXI_SIZEW-1:0]  o_awsize,
    output logic [AXI_BURSTW-1:0] o_awburst,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [B_DW-1:0]       o_wdata,
    output logic [B_BPD-1:0]      o_wstrb,
    output logic                  o_wlast,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    input  logic                  i_bvalid,
    input  logic [1:0]            i_bresp,
    output logic                  o_bready
);

    localparam int unsigned LSB = $clog2(B_BPD);
    localparam int unsigned CW  = $clog2(MAX_BURST + 1);
    localparam int unsigned PGW = (B_AW < 12) ? B_AW : 12;
    localparam int unsigned FW  = B_DW + B_BPD;

    state_t                r_state;
    state_t                w_state_d;
    logic [B_AW-1:0]       r_base;
    logic [CW-1:0]         r_count;
    logic [B_AW-1:0]       r_awaddr;
    logic [AXI_LENW-1:0]   r_awlen;
    logic                  r_bready;
    logic [B_AW-1:0]       w_align;
    logic [B_AW-1:0]       w_next;
    logic                  w_contig;
    logic                  w_room;
    logic                  w_pg_ok;
    logic                  w_wrrdy;
    logic                  w_accept;
    logic                  w_frd;
    logic                  w_last;
    logic [FW-1:0]         w_fdata;
    logic [CW-1:0]         w_fcnt;

    assign w_align  = i_wraddr & ~B_AW'(B_BPD - 1);
    assign w_next   = r_base + (B_AW'(r_count) << LSB);
    assign w_contig = (w_align == w_next);
    assign w_room   = (r_count < CW'(MAX_BURST));
    // A burst may not run onto a 4 KB boundary.
    assign w_pg_ok  = (w_next[PGW-1:0] != '0);
    assign w_accept = i_wrvld && w_wrrdy;
    assign w_frd    = (r_state == StData) && i_wready;
    assign w_last   = (w_fcnt == CW'(1));

    ipmaxi_wr_buf #(
        .DEPTH (MAX_BURST),
        .W     (FW),
        .CW    (CW)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (w_accept),
        .i_wdata ({i_wrdata, i_wrbe}),
        .i_rd    (w_frd),
        .o_rdata (w_fdata),
        .o_count (w_fcnt)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:    if (w_accept)             w_state_d = StCollect;
            StCollect: if (!w_accept)            w_state_d = StAddr;
            StAddr:    if (i_awready)            w_state_d = StData;
            StData:    if (i_wready && w_last)   w_state_d = StIdle;
            default:                             w_state_d = StIdle;
        endcase
    end

    // r_bready doubles as the "out of reset" flag that keeps wrrdy low during reset.
    always_comb begin
        w_wrrdy = 1'b0;
        case (r_state)
            StIdle:    w_wrrdy = r_bready;
            StCollect: w_wrrdy = w_contig && w_room && w_pg_ok;
            default:   w_wrrdy = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_base   <= '0;
            r_count  <= '0;
            r_awaddr <= '0;
            r_awlen  <= '0;
            r_bready <= 1'b0;
        end else begin
            r_bready <= 1'b1;
            if (w_accept) begin
                if (r_state == StIdle) begin
                    r_base  <= w_align;
                    r_count <= CW'(1);
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else if (r_state == StCollect) begin
                r_awaddr <= r_base;
                r_awlen  <= AXI_LENW'(r_count - CW'(1));
            end
            if ((r_state == StData) && i_wready && w_last) begin
                r_count <= '0;
            end
        end
    end

    assign o_wrrdy   = w_wrrdy;
    assign o_wrnf    = (w_fcnt >= CW'(MAX_BURST - 1)) || (r_state == StAddr) ||
                       (r_state == StData);
    assign o_awvalid = (r_state == StAddr);
    assign o_awaddr  = r_awaddr;
    assign o_awlen   = r_awlen;
    assign o_awsize  = AXI_SIZEW'(LSB);
    assign o_awburst = AXI_BURST_INCR;
    assign o_wvalid  = (r_state == StData);
    assign o_wlast   = o_wvalid && w_last;
    assign o_wdata   = o_wvalid ? w_fdata[FW-1:B_BPD] : '0;
    assign o_wstrb   = o_wvalid ? w_fdata[B_BPD-1:0] : '0;
    assign o_bready  = r_bready;

`ifdef IPMAXI_WR_DEBUG_EN
    always @(posedge i_clk) begin
        if (i_rst && (EDBG != 0)) begin
            if (o_awvalid && i_awready) begin
                $display("%s: AW addr=%h len=%0d", ID, o_awaddr, o_awlen);
            end
            if (i_bvalid && (i_bresp != 2'b00)) begin
                $display("%s: B response error bresp=%0d", ID, i_bresp);
            end
        end
    end
`endif

    logic w_unused;
    assign w_unused = ^{i_bvalid, i_bresp, EAR[0], EDBG[0], ID[7:0]};

endmodule

// File: tb/tb_ipmaxi_wr.sv
// Directed self-checking bench for ipmaxi_wr (default parameters: 128-beat bursts, 32-bit bus).
module tb_ipmaxi_wr;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wraddr;
    logic [31:0] wrdata;
    logic [3:0]  wrbe;
    logic        wrvld;
    logic        wrrdy;
    logic        wrnf;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] aw_addr_q [$];
    logic [7:0]  aw_len_q  [$];
    logic [2:0]  aw_size_q [$];
    logic [1:0]  aw_bur_q  [$];
    logic [31:0] w_data_q  [$];
    logic [3:0]  w_strb_q  [$];
    logic        w_last_q  [$];

    always #5 clk = ~clk;

    ipmaxi_wr dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wraddr  (wraddr),
        .i_wrdata  (wrdata),
        .i_wrbe    (wrbe),
        .i_wrvld   (wrvld),
        .o_wrrdy   (wrrdy),
        .o_wrnf    (wrnf),
        .o_awaddr  (awaddr),
        .o_awlen   (awlen),
        .o_awsize  (awsize),
        .o_awburst (awburst),
        .o_awvalid (awvalid),
        .i_awready (awready),
        .o_wdata   (wdata),
        .o_wstrb   (wstrb),
        .o_wlast   (wlast),
        .o_wvalid  (wvalid),
        .i_wready  (wready),
        .i_bvalid  (bvalid),
        .i_bresp   (bresp),
        .o_bready  (bready)
    );

    // Slave-side recorder: handshakes seen at negedge complete at the following posedge.
    always @(negedge clk) begin
        if (rst) begin
            if (awvalid && awready) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(awlen);
                aw_size_q.push_back(awsize);
                aw_bur_q.push_back(awburst);
            end
            if (wvalid && wready) begin
                w_data_q.push_back(wdata);
                w_strb_q.push_back(wstrb);
                w_last_q.push_back(wlast);
            end
        end
    end

    task automatic clear_q();
        aw_addr_q.delete(); aw_len_q.delete(); aw_size_q.delete(); aw_bur_q.delete();
        w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int n = 0;
        wraddr = a; wrdata = d; wrbe = be; wrvld = 1'b1;
        @(negedge clk);
        while (!wrrdy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (wrrdy !== 1'b1) begin
            failures++;
            $display("FAIL send_beat_timeout addr=%h wrrdy=%b required 1", a, wrrdy);
        end
        @(posedge clk); #1;
        wrvld = 1'b0;
    endtask

    task automatic wait_counts(input int naw, input int nw, input string name);
        int n = 0;
        while ((aw_addr_q.size() < naw || w_data_q.size() < nw) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (aw_addr_q.size() != naw || w_data_q.size() != nw) begin
            failures++;
            $display("FAIL %s_counts aw=%0d w=%0d required aw=%0d w=%0d",
                     name, aw_addr_q.size(), w_data_q.size(), naw, nw);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; wrvld = 1'b0; wraddr = '0; wrdata = '0; wrbe = '0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
        #3;
        checks++;
        if ({wrrdy, awvalid, wvalid, wlast, bready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got wrrdy/awv/wv/wlast/bready=%b required 00000",
                     {wrrdy, awvalid, wvalid, wlast, bready});
        end
        checks++;
        if (awaddr !== 32'h0 || awlen !== 8'h0) begin
            failures++;
            $display("FAIL reset_aw got addr=%h len=%h required 0/0", awaddr, awlen);
        end
        checks++;
        if (wdata !== 32'h0 || wstrb !== 4'h0) begin
            failures++;
            $display("FAIL reset_w got data=%h strb=%h required 0/0", wdata, wstrb);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wrrdy !== 1'b1 || bready !== 1'b1 || wrnf !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got wrrdy=%b bready=%b wrnf=%b required 1/1/0",
                     wrrdy, bready, wrnf);
        end
    endtask

    task automatic test_single_burst();
        int n = 0;
        clear_q();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_beat(32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(i + 1));
        @(negedge clk);
        checks++;
        if (awvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_aw_early got awvalid=%b required 0", awvalid);
        end
        @(negedge clk);
        checks++;
        if (awvalid !== 1'b1 || wrrdy !== 1'b0 || wrnf !== 1'b1) begin
            failures++;
            $display("FAIL single_addr_phase got awvalid=%b wrrdy=%b wrnf=%b required 1/0/1",
                     awvalid, wrrdy, wrnf);
        end
        @(negedge clk);
        checks++;
        if (wvalid !== 1'b1 || wdata !== 32'hA000_0000) begin
            failures++;
            $display("FAIL single_first_w got wvalid=%b wdata=%h required 1/a0000000", wvalid, wdata);
        end
        while (!(wvalid && wready && wlast) && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (wrrdy !== 1'b1) begin
            failures++;
            $display("FAIL single_turnaround got wrrdy=%b required 1", wrrdy);
        end
        wait_counts(1, 4, "single");
        checks++;
        if (aw_addr_q[0] !== 32'h100 || aw_len_q[0] !== 8'd3 || aw_size_q[0] !== 3'd2 ||
            aw_bur_q[0] !== 2'b01) begin
            failures++;
            $display("FAIL single_aw got addr=%h len=%0d size=%0d burst=%0d required 100/3/2/1",
                     aw_addr_q[0], aw_len_q[0], aw_size_q[0], aw_bur_q[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_data_q[i] !== 32'hA000_0000 + 32'(i) || w_strb_q[i] !== 4'(i + 1) ||
                w_last_q[i] !== (i == 3)) begin
                failures++;
                $display("FAIL single_w%0d got data=%h strb=%h last=%b required %h/%h/%b", i,
                         w_data_q[i], w_strb_q[i], w_last_q[i], 32'hA000_0000 + 32'(i),
                         4'(i + 1), (i == 3));
            end
        end
    endtask

    task automatic test_max_burst();
        clear_q();
        @(posedge clk); #1;
        for (int i = 0; i < 130; i++) send_beat(32'(i * 4), 32'hC000_0000 + 32'(i), 4'hF);
        wait_counts(2, 130, "max");
        checks++;
        if (aw_addr_q[0] !== 32'h0 || aw_len_q[0] !== 8'd127) begin
            failures++;
            $display("FAIL max_aw0 got addr=%h len=%0d required 0/127", aw_addr_q[0], aw_len_q[0]);
        end
        checks++;
        if (aw_addr_q[1] !== 32'h200 || aw_len_q[1] !== 8'd1) begin
            failures++;
            $display("FAIL max_aw1 got addr=%h len=%0d required 200/1", aw_addr_q[1], aw_len_q[1]);
        end
        checks++;
        if ({w_last_q[126], w_last_q[127], w_last_q[128], w_last_q[129]} !== 4'b0101) begin
            failures++;
            $display("FAIL max_wlast got %b required 0101",
                     {w_last_q[126], w_last_q[127], w_last_q[128], w_last_q[129]});
        end
        checks++;
        if (w_data_q[128] !== 32'hC000_0080 || w_data_q[127] !== 32'hC000_007F) begin
            failures++;
            $display("FAIL max_wdata got %h/%h required c000007f/c0000080",
                     w_data_q[127], w_data_q[128]);
        end
    endtask

    task automatic test_4k();
        clear_q();
        @(posedge clk); #1;
        send_beat(32'hFF8, 32'h0000_0FF8, 4'hF);
        send_beat(32'hFFC, 32'h0000_0FFC, 4'hF);
        send_beat(32'h1000, 32'h0000_1000, 4'hF);
        wait_counts(2, 3, "4k");
        checks++;
        if (aw_addr_q[0] !== 32'hFF8 || aw_len_q[0] !== 8'd1 ||
            aw_addr_q[1] !== 32'h1000 || aw_len_q[1] !== 8'd0) begin
            failures++;
            $display("FAIL 4k_aw got %h/%0d %h/%0d required ff8/1 1000/0",
                     aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
        end
        checks++;
        if ({w_last_q[0], w_last_q[1], w_last_q[2]} !== 3'b011 || w_data_q[2] !== 32'h1000) begin
            failures++;
            $display("FAIL 4k_w got last=%b data2=%h required 011/1000",
                     {w_last_q[0], w_last_q[1], w_last_q[2]}, w_data_q[2]);
        end
    endtask

    task automatic test_noncontig();
        int n = 0;
        clear_q();
        @(posedge clk); #1;
        send_beat(32'h0, 32'h1111_1111, 4'hF);
        wraddr = 32'h40; wrdata = 32'h2222_2222; wrbe = 4'h5; wrvld = 1'b1;
        @(negedge clk);
        checks++;
        if (wrrdy !== 1'b0) begin
            failures++;
            $display("FAIL noncontig_hold got wrrdy=%b required 0", wrrdy);
        end
        while (!wrrdy && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (wrrdy !== 1'b1 || w_data_q.size() != 1) begin
            failures++;
            $display("FAIL noncontig_accept got wrrdy=%b wbeats=%0d required 1/1",
                     wrrdy, w_data_q.size());
        end
        @(posedge clk); #1;
        wrvld = 1'b0;
        wait_counts(2, 2, "noncontig");
        checks++;
        if (aw_addr_q[0] !== 32'h0 || aw_len_q[0] !== 8'd0 ||
            aw_addr_q[1] !== 32'h40 || aw_len_q[1] !== 8'd0) begin
            failures++;
            $display("FAIL noncontig_aw got %h/%0d %h/%0d required 0/0 40/0",
                     aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
        end
        checks++;
        if (w_data_q[1] !== 32'h2222_2222 || w_strb_q[1] !== 4'h5 || w_last_q[1] !== 1'b1) begin
            failures++;
            $display("FAIL noncontig_w got %h/%h/%b required 22222222/5/1",
                     w_data_q[1], w_strb_q[1], w_last_q[1]);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        clear_q();
        @(posedge clk); #1;
        awready = 1'b0; wready = 1'b0;
        send_beat(32'h300, 32'hD0D0_D0D0, 4'h3);
        send_beat(32'h304, 32'hD1D1_D1D1, 4'hC);
        @(negedge clk);
        while (!awvalid && n < 20) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if ({awvalid, awaddr, awlen} !== {1'b1, 32'h300, 8'd1}) begin
                failures++;
                $display("FAIL stall_aw%0d got v=%b addr=%h len=%0d required 1/300/1",
                         i, awvalid, awaddr, awlen);
            end
        end
        @(posedge clk); #1; awready = 1'b1;
        @(posedge clk); #1; awready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({wvalid, wdata, wstrb, wlast} !== {1'b1, 32'hD0D0_D0D0, 4'h3, 1'b0}) begin
                failures++;
                $display("FAIL stall_w0_%0d got v=%b data=%h strb=%h last=%b required 1/d0d0d0d0/3/0",
                         i, wvalid, wdata, wstrb, wlast);
            end
        end
        @(posedge clk); #1; wready = 1'b1;
        @(posedge clk); #1; wready = 1'b0;
        @(negedge clk);
        checks++;
        if ({wvalid, wdata, wstrb, wlast} !== {1'b1, 32'hD1D1_D1D1, 4'hC, 1'b1}) begin
            failures++;
            $display("FAIL stall_w1 got v=%b data=%h strb=%h last=%b required 1/d1d1d1d1/c/1",
                     wvalid, wdata, wstrb, wlast);
        end
        @(posedge clk); #1; wready = 1'b1;
        wait_counts(1, 2, "stall");
        awready = 1'b1;
        checks++;
        if (aw_addr_q[0] !== 32'h300 || w_data_q[0] !== 32'hD0D0_D0D0 ||
            w_data_q[1] !== 32'hD1D1_D1D1) begin
            failures++;
            $display("FAIL stall_q got aw=%h w0=%h w1=%h required 300/d0d0d0d0/d1d1d1d1",
                     aw_addr_q[0], w_data_q[0], w_data_q[1]);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_q();
        @(posedge clk); #1;
        awready = 1'b0;
        send_beat(32'h400, 32'h4444_0000, 4'hF);
        send_beat(32'h404, 32'h4444_0001, 4'hF);
        @(negedge clk);
        while (!awvalid && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({awvalid, wvalid, wrrdy, bready} !== 4'b0 || awaddr !== 32'h0) begin
            failures++;
            $display("FAIL midreset_out got awv/wv/wrrdy/bready=%b awaddr=%h required 0000/0",
                     {awvalid, wvalid, wrrdy, bready}, awaddr);
        end
        @(negedge clk);
        rst = 1'b1; awready = 1'b1;
        clear_q();
        @(posedge clk); #1;
        send_beat(32'h500, 32'h5555_5555, 4'hF);
        wait_counts(1, 1, "midreset");
        repeat (5) @(negedge clk);
        checks++;
        if (aw_addr_q.size() != 1 || w_data_q.size() != 1 || aw_addr_q[0] !== 32'h500 ||
            aw_len_q[0] !== 8'd0 || w_data_q[0] !== 32'h5555_5555 || w_last_q[0] !== 1'b1) begin
            failures++;
            $display("FAIL midreset_after got naw=%0d nw=%0d aw=%h len=%0d w=%h required 1/1/500/0/55555555",
                     aw_addr_q.size(), w_data_q.size(), aw_addr_q[0], aw_len_q[0], w_data_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_max_burst();
        test_4k();
        test_noncontig();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
